// File: rtl/class_mem_banked.sv
// Class-hypervector store: byte-serial round-robin load into M_SIZE banks, one M_SIZE-element word read per address.
// Optional CLASS_MEM_OUT_REG_EN adds a second output register stage (read latency 2 instead of 1).
module class_mem_banked #(
    parameter int FTWIDTH    = 8,
    parameter int M_SIZE     = 16,
    parameter int DEPTH      = 6500,
    parameter int ADDR_WIDTH = 13,
    parameter int CNT_WIDTH  = $clog2(M_SIZE*DEPTH+1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [FTWIDTH-1:0]          class_in,
    input  logic                        class_valid,
    input  logic                        we,
    input  logic                        re,
    input  logic [ADDR_WIDTH-1:0]       read_address,
    input  logic                        restart,
    output logic [M_SIZE*FTWIDTH-1:0]   class_out,
    output logic                        out_valid,
    output logic                        write_done,
    output logic [CNT_WIDTH-1:0]        write_count,
    output logic                        rd_err
);
    localparam int BW = $clog2(M_SIZE);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [BW-1:0]         B_LAST  = BW'(M_SIZE-1);
    localparam logic [IW-1:0]         W_LAST  = IW'(DEPTH-1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic {LOAD, DONE} state_e;

    state_e               state_q, state_d;
    logic [BW-1:0]        b_q, b_d;
    logic [IW-1:0]        w_q, w_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 s1_vld_q;
    logic [M_SIZE*FTWIDTH-1:0] s1_dat;

    logic          loading, wr_acc, rd_acc, rd_oor;
    logic [IW-1:0] rd_idx;

    // A read is dropped whenever load mode is active, even during a stall.
    assign loading = we & (state_q == LOAD);
    assign wr_acc  = loading & class_valid & ~restart;
    assign rd_acc  = re & ~loading;
    assign rd_oor  = {1'b0, read_address} >= DEPTH_L;
    assign rd_idx  = read_address[IW-1:0];

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (restart) begin
            state_d = LOAD;
            b_d     = '0;
            w_d     = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else begin
            if (wr_acc) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (b_q == B_LAST) begin
                    b_d = '0;
                    if (w_q == W_LAST) begin
                        state_d = DONE;
                        w_d     = '0;
                    end else begin
                        w_d = w_q + IW'(1);
                    end
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            if (re & (loading | rd_oor))
                err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= LOAD;
            b_q      <= '0;
            w_q      <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            s1_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            s1_vld_q <= rd_acc;
        end
    end

    for (genvar k = 0; k < M_SIZE; k++) begin : g_bank
        logic [FTWIDTH-1:0] mem [DEPTH];
        logic [FTWIDTH-1:0] dat_q;

        always_ff @(posedge clk) begin
            if (wr_acc && (b_q == BW'(k)))
                mem[w_q] <= class_in;
        end

        // Out-of-range reads return zero rather than aliasing into the array.
        always_ff @(posedge clk) begin
            if (reset)
                dat_q <= '0;
            else if (rd_acc)
                dat_q <= rd_oor ? '0 : mem[rd_idx];
        end

        assign s1_dat[k*FTWIDTH +: FTWIDTH] = dat_q;
    end

`ifdef CLASS_MEM_OUT_REG_EN
    logic [M_SIZE*FTWIDTH-1:0] s2_dat_q;
    logic                      s2_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_dat_q <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q)
                s2_dat_q <= s1_dat;
        end
    end

    assign class_out = s2_dat_q;
    assign out_valid = s2_vld_q;
`else
    assign class_out = s1_dat;
    assign out_valid = s1_vld_q;
`endif

    assign write_done  = (state_q == DONE);
    assign write_count = cnt_q;
    assign rd_err      = err_q;
endmodule

// File: tb/tb_class_mem_banked.sv
// Directed self-checking bench for class_mem_banked at M_SIZE=4, DEPTH=8, FTWIDTH=8.
module tb_class_mem_banked;
    localparam int FW = 8, MS = 4, DP = 8, AW = 4, CW = 6;
`ifdef CLASS_MEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [FW-1:0] class_in = '0;
    logic          class_valid = 1'b0, we = 1'b0, re = 1'b0, restart = 1'b0;
    logic [AW-1:0] read_address = '0;
    logic [MS*FW-1:0] class_out;
    logic          out_valid, write_done, rd_err;
    logic [CW-1:0] write_count;

    int vectors = 0;
    int miscompares = 0;

    class_mem_banked #(.FTWIDTH(FW), .M_SIZE(MS), .DEPTH(DP), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .class_in(class_in), .class_valid(class_valid), .we(we), .re(re),
        .read_address(read_address), .restart(restart), .class_out(class_out), .out_valid(out_valid),
        .write_done(write_done), .write_count(write_count), .rd_err(rd_err));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] seq_word(input int a);
        logic [7:0] b0, b1, b2, b3;
        b0 = 8'(4*a); b1 = 8'(4*a+1); b2 = 8'(4*a+2); b3 = 8'(4*a+3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic stream(input int n, input int base, input bit inc);
        we = 1'b1; class_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            class_in = inc ? 8'(base + i) : 8'(base);
            tick();
        end
        we = 1'b0; class_valid = 1'b0;
    endtask

    task automatic read_word(input int a);
        re = 1'b1; read_address = AW'(a);
        tick();
        re = 1'b0;
        for (int i = 1; i < LAT; i++) tick();
    endtask

    task automatic pulse_restart();
        restart = 1'b1; tick(); restart = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        vectors++; if (class_out !== '0) begin miscompares++; $display("FAIL reset_class_out: got %h expected 0", class_out); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (write_done !== 1'b0) begin miscompares++; $display("FAIL reset_write_done: got %b expected 0", write_done); end
        vectors++; if (write_count !== '0) begin miscompares++; $display("FAIL reset_write_count: got %0d expected 0", write_count); end
        vectors++; if (rd_err !== 1'b0) begin miscompares++; $display("FAIL reset_rd_err: got %b expected 0", rd_err); end
    endtask

    task automatic test_load();
        stream(31, 0, 1'b1);
        vectors++; if (write_done !== 1'b0) begin miscompares++; $display("FAIL load_done_early: got %b expected 0", write_done); end
        stream(1, 31, 1'b1);
        vectors++; if (write_done !== 1'b1) begin miscompares++; $display("FAIL load_done: got %b expected 1", write_done); end
        vectors++; if (write_count !== 6'd32) begin miscompares++; $display("FAIL load_count: got %0d expected 32", write_count); end
        read_word(3);
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL load_rd_valid: got %b expected 1", out_valid); end
        vectors++; if (class_out !== 32'h0F0E0D0C) begin miscompares++; $display("FAIL load_rd_addr3: got %h expected 0f0e0d0c", class_out); end
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL load_valid_drop: got %b expected 0", out_valid); end
    endtask

    task automatic test_stall();
        pulse_restart();
        vectors++; if (write_count !== '0 || write_done !== 1'b0) begin miscompares++; $display("FAIL stall_restart: got cnt %0d done %b expected 0/0", write_count, write_done); end
        we = 1'b1;
        for (int i = 0; i < 64; i++) begin
            class_valid = (i % 2 == 0);
            class_in = class_valid ? 8'(i/2) : 8'hEE;
            tick();
            if (i == 61) begin
                vectors++; if (write_done !== 1'b0 || write_count !== 6'd31) begin miscompares++; $display("FAIL stall_31: got done %b cnt %0d expected 0/31", write_done, write_count); end
            end
            if (i == 62) begin
                vectors++; if (write_done !== 1'b1) begin miscompares++; $display("FAIL stall_done: got %b expected 1", write_done); end
            end
        end
        we = 1'b0; class_valid = 1'b0;
        vectors++; if (write_count !== 6'd32) begin miscompares++; $display("FAIL stall_count: got %0d expected 32", write_count); end
        for (int a = 0; a < 8; a++) begin
            read_word(a);
            vectors++; if (class_out !== seq_word(a) || out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_rd%0d: got %h v%b expected %h v1", a, class_out, out_valid, seq_word(a)); end
        end
    endtask

    task automatic test_after_done();
        stream(5, 8'hFF, 1'b0);
        vectors++; if (write_count !== 6'd32) begin miscompares++; $display("FAIL done_count_hold: got %0d expected 32", write_count); end
        read_word(0);
        vectors++; if (class_out !== 32'h03020100) begin miscompares++; $display("FAIL done_rd0: got %h expected 03020100", class_out); end
    endtask

    task automatic test_read_while_load();
        pulse_restart();
        tick();
        we = 1'b1; class_valid = 1'b1; class_in = 8'd0; re = 1'b1; read_address = 4'd2;
        tick();
        re = 1'b0;
        vectors++; if (write_count !== 6'd1) begin miscompares++; $display("FAIL rwl_count: got %0d expected 1", write_count); end
        vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL rwl_rd_err: got %b expected 1", rd_err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rwl_valid_a: got %b expected 0", out_valid); end
        class_in = 8'd1;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rwl_valid_b: got %b expected 0", out_valid); end
        stream(30, 2, 1'b1);
        vectors++; if (write_done !== 1'b1) begin miscompares++; $display("FAIL rwl_done: got %b expected 1", write_done); end
        pulse_restart();
        vectors++; if (rd_err !== 1'b0 || write_count !== '0 || write_done !== 1'b0) begin miscompares++; $display("FAIL rwl_restart: got err %b cnt %0d done %b expected 0/0/0", rd_err, write_count, write_done); end
        stream(32, 0, 1'b1);
    endtask

    task automatic test_oor_back_to_back();
        read_word(8);
        vectors++; if (class_out !== '0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL oor_read: got %h v%b expected 0 v1", class_out, out_valid); end
        vectors++; if (rd_err !== 1'b1) begin miscompares++; $display("FAIL oor_rd_err: got %b expected 1", rd_err); end
        tick();
        for (int j = 0; j < 8 + LAT; j++) begin
            re = (j < 8); read_address = AW'(j);
            tick();
            if (j >= LAT - 1 && j < 8 + LAT - 1) begin
                vectors++; if (out_valid !== 1'b1 || class_out !== seq_word(j - LAT + 1)) begin miscompares++; $display("FAIL b2b_rd%0d: got %h v%b expected %h v1", j - LAT + 1, class_out, out_valid, seq_word(j - LAT + 1)); end
            end
        end
        re = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end_valid: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_midload();
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++; if (class_out !== '0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out: got %h v%b expected 0 v0", class_out, out_valid); end
        vectors++; if (rd_err !== 1'b0 || write_done !== 1'b0) begin miscompares++; $display("FAIL rst_flags: got err %b done %b expected 0/0", rd_err, write_done); end
        stream(10, 8'h11, 1'b0);
        vectors++; if (write_count !== 6'd10) begin miscompares++; $display("FAIL mid_count: got %0d expected 10", write_count); end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++; if (write_count !== '0) begin miscompares++; $display("FAIL mid_reset_count: got %0d expected 0", write_count); end
        stream(32, 8'hA5, 1'b0);
        vectors++; if (write_done !== 1'b1 || write_count !== 6'd32) begin miscompares++; $display("FAIL a5_done: got done %b cnt %0d expected 1/32", write_done, write_count); end
        for (int a = 0; a < 8; a++) begin
            read_word(a);
            vectors++; if (class_out !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL a5_rd%0d: got %h expected a5a5a5a5", a, class_out); end
        end
    endtask

    task automatic test_restart_coincident();
        pulse_restart();
        we = 1'b1; class_valid = 1'b1; class_in = 8'h42; restart = 1'b1;
        tick();
        restart = 1'b0;
        vectors++; if (write_count !== '0) begin miscompares++; $display("FAIL rs_coinc_count: got %0d expected 0", write_count); end
        tick();
        we = 1'b0; class_valid = 1'b0;
        vectors++; if (write_count !== 6'd1) begin miscompares++; $display("FAIL rs_next_count: got %0d expected 1", write_count); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_after_done();
        test_read_while_load();
        test_oor_back_to_back();
        test_reset_midload();
        test_restart_coincident();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
